// File: rtl/sm_als_responder.sv
// sm_als_responder: SPI responder modelling the ambient light sensor ADC, shifting {3'b000, sample, 5'b00000} MSB first.
// Ports: clk/rst_n (async active-low), sample (latched at frame start), alsCS/alsSCK (from master),
//        alsSDO/alsSdoEn (to master), busy, frameDone (1-cycle pulse), frameShort (with frameDone),
//        sckCount (SCK falls this/last frame, saturating at 31).
// Build option: SM_CONFIG_ALS_RESP_SYNC_EN selects a 2-flop synchronizer per input (otherwise 1 flop).
module sm_als_responder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       alsCS,
  input  logic       alsSCK,
  output logic       alsSDO,
  output logic       alsSdoEn,
  output logic       busy,
  output logic       frameDone,
  output logic       frameShort,
  output logic [4:0] sckCount
);
`ifdef SM_CONFIG_ALS_RESP_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state;
  logic [DEPTH-1:0] r_cs_sync, r_sck_sync;
  logic             r_cs_prev, r_sck_prev;
  logic [15:0]      r_shift;
  logic             r_done, r_short;
  logic [4:0]       r_cnt;
  logic             w_cs, w_sck, w_cs_fall, w_cs_rise, w_sck_fall;
  assign w_cs       = r_cs_sync[DEPTH-1];
  assign w_sck      = r_sck_sync[DEPTH-1];
  assign w_cs_fall  = r_cs_prev & ~w_cs;
  assign w_cs_rise  = ~r_cs_prev & w_cs;
  assign w_sck_fall = r_sck_prev & ~w_sck;
  assign alsSDO     = r_shift[15];
  assign alsSdoEn   = (r_state == SHIFT);
  assign busy       = (r_state == SHIFT);
  assign frameDone  = r_done;
  assign frameShort = r_short;
  assign sckCount   = r_cnt;
  // Chains and prev reset high so an idle bus produces no edge out of reset;
  // the shift register is cleared on frame end so SDO idles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync  <= '1;
      r_sck_sync <= '1;
      r_cs_prev  <= 1'b1;
      r_sck_prev <= 1'b1;
      r_state    <= IDLE;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_short    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_cs_sync  <= DEPTH'({r_cs_sync, alsCS});
      r_sck_sync <= DEPTH'({r_sck_sync, alsSCK});
      r_cs_prev  <= w_cs;
      r_sck_prev <= w_sck;
      r_done     <= 1'b0;
      r_short    <= 1'b0;
      if (r_state == IDLE) begin
        if (w_cs_fall) begin
          r_state <= SHIFT;
          r_shift <= {3'b000, sample, 5'b00000};
          r_cnt   <= '0;
        end
      end else if (w_cs_rise) begin
        r_state <= IDLE;
        r_shift <= '0;
        r_done  <= 1'b1;
        r_short <= ~r_cnt[4];
      end else if (w_sck_fall) begin
        r_shift <= {r_shift[14:0], 1'b0};
        r_cnt   <= r_cnt + {4'b0000, ~&r_cnt};
      end
    end
  end
endmodule
